r_result_tx: RTL and testbench
==============================

# r_result_tx

Synthesizable result transmitter for the R-type CPU. It captures each retired result (F, ZF, OF) into a small FIFO and serializes it onto a UART-style line, so board runs can be read out by a host. It performs in hardware the observation role the simulation fixture plays, and sits beside the CPU top on the shared clk/rst.

## Interface
Parameters:
- CLK_DIV, 16: clock cycles per serial bit; integer, ≥2.
- DEPTH, 8: FIFO entries; power of 2, 2..64.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- valid  input  1  result strobe; one result per high cycle.
- F  input  32  ALU result.
- ZF  input  1  zero flag.
- OF  input  1  overflow flag.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever the serializer is not IDLE.
- full  output  1  FIFO holds DEPTH entries.
- drop_cnt  output  8  count of rejected results; saturates at 255.

## Operation
- Record format: 5 bytes, in order: {6'b0, OF, ZF}, F[31:24], F[23:16], F[15:8], F[7:0].
- Byte frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held CLK_DIV cycles.
- FIFO write: at a rising edge with valid=1 and full=0 (full sampled before the edge), {OF, ZF, F} is written.
- Drop: valid=1 with full=1 rejects the result and increments drop_cnt, stopping at 255. A same-edge pop does not rescue the write.
- Serializer FSM: IDLE → START → DATA (8 bits) → [PARITY] → STOP.
  - After STOP: go to START of the next byte if byte index < 4.
  - Otherwise, go to START of a new record if the FIFO is non-empty, else to IDLE.
  - There is no idle gap between bytes or between back-to-back records.
- Pop: the FIFO head is popped at the edge where IDLE (or the final STOP) loads a new record into a 34-bit shift holding register.
- Simultaneous pop and write: both occur; count is unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are derived from the MSB/low-bit comparison.

## Timing
- Reset values: tx=1, busy=0, full=0, drop_cnt=0. The FIFO is emptied, the FSM goes to IDLE, and the bit and byte counters are 0.
- Reset asserted mid-frame forces tx high immediately (asynchronous). The partial frame is abandoned and not resumed.
- Latency, with the FIFO empty and FSM IDLE:
  - valid is sampled at edge N and written at N.
  - The record is popped at N+1; tx=0 and busy=1 are registered at N+1.
- Frame duration: 10·CLK_DIV cycles per byte (11·CLK_DIV with parity), so 50·CLK_DIV cycles per record.
- busy falls at the edge ending the final stop bit when the FIFO is empty.
- full rises at the edge the DEPTH-th entry is written and falls at the edge of the pop.
- tx is driven directly from a flop (glitch-free).

## Configuration
- TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit. This gives 11 bits per byte and 55·CLK_DIV cycles per record.
- TX_PARITY_EN undefined: no parity state, 10 bits per byte.

## Test plan
Use CLK_DIV=4 and DEPTH=8 unless stated.
- Single record: one strobe with F=0x12345678, ZF=0, OF=1 → bytes 0x02, 0x12, 0x34, 0x56, 0x78 decoded on tx. tx low at N+1; busy high for exactly 200 cycles; drop_cnt=0.
- Zero result: F=0x00000000, ZF=1, OF=0 → bytes 0x01, 0x00, 0x00, 0x00, 0x00. Then a second strobe is issued 20 cycles later → its record starts with no gap immediately after the first stop bit.
- Overflow: 12 consecutive strobes with F=1..12 → results 1..9 transmitted in order. full is high after the 9th edge; drop_cnt=3; records 10..12 never appear.
- Saturation: hold the line full and issue 300 strobes → drop_cnt=255 and stays there.
- Reset mid-operation: assert rst during the data bits of byte 2 → tx=1, busy=0, full=0, and drop_cnt=0 immediately without a clock. After release, a new strobe with F=0xA5A5A5A5 transmits cleanly.
- With TX_PARITY_EN and F=0x12345678, OF=1, ZF=0 → parity bits 1, 0, 1, 0, 0. Record length is 220 cycles.

Source files
------------

// File: rtl/r_result_tx.sv
// rtl/r_result_tx.sv - result FIFO plus UART-style serializer for retired R-type results
// Optional even parity bit per byte when TX_PARITY_EN is defined.
module r_result_tx #(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] F,
    input  logic        ZF,
    input  logic        OF,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic [7:0]  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t         state_q, state_d;
    logic [33:0]    mem_q [DEPTH];
    logic [AW:0]    wr_q, rd_q;
    logic [DW-1:0]  div_q, div_d;
    logic [2:0]     bit_q, bit_d;
    logic [2:0]     byte_q, byte_d;
    logic [33:0]    hold_q, hold_d;
    logic           tx_q, tx_d;
    logic [7:0]     drop_q;
    logic           empty, full_w, push, pop, bit_done;
    logic [7:0]     cur_byte;

    assign empty    = (wr_q == rd_q);
    assign full_w   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push     = valid && !full_w;
    assign bit_done = (div_q == DIV_LAST);

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign full     = full_w;
    assign drop_cnt = drop_q;

    // Byte 0 carries the flags; bytes 1..4 carry F most-significant first.
    function automatic logic [7:0] rec_byte(input logic [33:0] r, input logic [2:0] idx);
        case (idx)
            3'd0:    return {6'b0, r[33:32]};
            3'd1:    return r[31:24];
            3'd2:    return r[23:16];
            3'd3:    return r[15:8];
            default: return r[7:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {OF, ZF, F};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (valid && full_w && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_START;
                    hold_d  = mem_q[rd_q[AW-1:0]];
                    pop     = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            S_START: begin
                div_d = bit_done ? '0 : div_q + 1'b1;
                if (bit_done) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                div_d = bit_done ? '0 : div_q + 1'b1;
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                div_d = bit_done ? '0 : div_q + 1'b1;
                if (bit_done) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                div_d = bit_done ? '0 : div_q + 1'b1;
                if (bit_done) begin
                    bit_d = '0;
                    if (byte_q != 3'd4) begin
                        state_d = S_START;
                        byte_d  = byte_q + 3'd1;
                    end else if (!empty) begin
                        // Chain straight into the next record with no idle gap.
                        state_d = S_START;
                        hold_d  = mem_q[rd_q[AW-1:0]];
                        pop     = 1'b1;
                        byte_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        byte_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is computed from the next state so the line comes straight off tx_q.
    always_comb begin
        cur_byte = rec_byte(hold_d, byte_d);
        tx_d     = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte[bit_d];
`ifdef TX_PARITY_EN
            S_PARITY: tx_d = ^cur_byte;
`endif
            default:  tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_r_result_tx.sv
// tb/tb_r_result_tx.sv - scoreboard bench decoding the serial line of r_result_tx
module tb_r_result_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
`ifdef TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int REC_CYC = 5 * BITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] F = '0;
    logic        ZF = 1'b0;
    logic        OF = 1'b0;
    logic        tx, busy, full;
    logic [7:0]  drop_cnt;

    r_result_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid(valid), .F(F), .ZF(ZF), .OF(OF),
        .tx(tx), .busy(busy), .full(full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         gap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [31:0] f, input logic zf, input logic of, input bit first_gap);
        q.push_back('{b: {6'b0, of, zf}, gap: first_gap});
        q.push_back('{b: f[31:24], gap: 1'b1});
        q.push_back('{b: f[23:16], gap: 1'b1});
        q.push_back('{b: f[15:8],  gap: 1'b1});
        q.push_back('{b: f[7:0],   gap: 1'b1});
    endtask

    task automatic strobe(input logic [31:0] f, input logic zf, input logic of);
        @(negedge clk);
        valid = 1'b1; F = f; ZF = zf; OF = of;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1 n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic latency_and_busy(input string tag);
        int n = 0;
        check({tag, "_tx_before"}, {31'b0, tx}, 32'd1);
        check({tag, "_busy_before"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_tx_low_n1"}, {31'b0, tx}, 32'd0);
        check({tag, "_busy_n1"}, {31'b0, busy}, 32'd1);
        while (busy && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, "_busy_cycles"}, n, REC_CYC);
    endtask

    // Monitor: decode frames on tx and compare against the scoreboard queue.
    initial begin
        int         start_cyc;
        int         last_start = -100000;
        bit         aborted;
        logic [7:0] data;
        logic       bits [BITS-1];
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst || tx) continue;
            start_cyc = cyc;
            aborted   = 1'b0;
            for (int i = 0; i < BITS - 1; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                bits[i] = tx;
            end
            if (aborted) continue;
            for (int i = 0; i < 8; i++) data[i] = bits[i];
            if (q.size() == 0) begin
                check("unexpected_byte", {24'b0, data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("byte", {24'b0, data}, {24'b0, e.b});
                if (e.gap)
                    check("no_gap", start_cyc - last_start, BITS * CLK_DIV);
`ifdef TX_PARITY_EN
                check("parity", {31'b0, bits[8]}, {31'b0, ^e.b});
`endif
            end
            check("stop_bit", {31'b0, bits[BITS-2]}, 32'd1);
            last_start = start_cyc;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_drop", {24'b0, drop_cnt}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single record.
        push_rec(32'h12345678, 1'b0, 1'b1, 1'b0);
        strobe(32'h12345678, 1'b0, 1'b1);
        latency_and_busy("single");
        check("single_drop", {24'b0, drop_cnt}, 32'd0);
        repeat (5) @(posedge clk);

        // Zero result followed by a second strobe that must chain without gap.
        push_rec(32'h00000000, 1'b1, 1'b0, 1'b0);
        push_rec(32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
        strobe(32'h00000000, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        strobe(32'hCAFEF00D, 1'b0, 1'b0);
        wait_idle(3 * REC_CYC);
        repeat (5) @(posedge clk);

        // Overflow: 12 back-to-back strobes, only 1..9 fit.
        for (int i = 1; i <= 9; i++) push_rec(i, 1'b0, 1'b0, i != 1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            valid = 1'b1; F = i; ZF = 1'b0; OF = 1'b0;
            @(posedge clk);
            #1;
            if (i == 8) check("ovf_full_edge8", {31'b0, full}, 32'd0);
            if (i == 9) check("ovf_full_edge9", {31'b0, full}, 32'd1);
        end
        valid = 1'b0;
        check("ovf_drop", {24'b0, drop_cnt}, 32'd3);
        wait_idle(10 * REC_CYC);
        check("ovf_full_after", {31'b0, full}, 32'd0);
        check("ovf_drop_after", {24'b0, drop_cnt}, 32'd3);
        repeat (5) @(posedge clk);

        // Saturation: 300 consecutive strobes against a full FIFO.
        push_rec(32'd1, 1'b0, 1'b0, 1'b0);
        push_rec(32'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            valid = 1'b1; F = i; ZF = 1'b0; OF = 1'b0;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        check("sat_drop", {24'b0, drop_cnt}, 32'd255);

        // Reset during data bits of byte 2 of record F=2 (byte value 0x00).
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_tx", {31'b0, tx}, 32'd0);
        check("pre_rst_full", {31'b0, full}, 32'd1);
        check("pre_rst_drop", {24'b0, drop_cnt}, 32'd255);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_tx", {31'b0, tx}, 32'd1);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_full", {31'b0, full}, 32'd0);
        check("async_rst_drop", {24'b0, drop_cnt}, 32'd0);
        q.delete();
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        push_rec(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        strobe(32'hA5A5A5A5, 1'b0, 1'b0);
        latency_and_busy("post_rst");
        check("post_rst_drop", {24'b0, drop_cnt}, 32'd0);

        repeat (10) @(posedge clk);
        check("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
